// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_sequencer : DECODE/EXEC/MEM/WB control FSM for mipscpu  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module multicycle_sequencer #(
   parameter int MEM_WAIT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             newinstr,
   input  logic [31:0]      instrword,
   output logic             ready,
   output logic [31:0]      ir,
   output logic             regdst,
   output logic             alusrc,
   output logic             memtoreg,
   output logic [1:0]       aluop,
   output logic             branch,
   output logic             regwrite,
   output logic             mem_cs,
   output logic             mem_we,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'd0;
   localparam logic [5:0] c_op_lw    = 6'd35;
   localparam logic [5:0] c_op_sw    = 6'd43;
   localparam logic [5:0] c_op_beq   = 6'd4;
   localparam logic [3:0] c_wait_ld  = 4'(MEM_WAIT - 1);

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [3:0]       wait_q, wait_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic w_is_r, w_is_lw, w_is_sw, w_is_beq;

   assign w_is_r   = (ir_q[31:26] == c_op_rtype);
   assign w_is_lw  = (ir_q[31:26] == c_op_lw);
   assign w_is_sw  = (ir_q[31:26] == c_op_sw);
   assign w_is_beq = (ir_q[31:26] == c_op_beq);

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      wait_d   = wait_q;
      ready    = 1'b0;
      regdst   = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      aluop    = 2'b00;
      branch   = 1'b0;
      regwrite = 1'b0;
      mem_cs   = 1'b0;
      mem_we   = 1'b0;
      done     = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (newinstr) begin
               ir_d    = instrword;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_is_r || w_is_lw || w_is_sw || w_is_beq) begin
               state_d = S_EXEC;
            end else begin
               illegal = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            if (w_is_r) begin
               aluop   = 2'b10;
               state_d = S_WB;
            end else if (w_is_beq) begin
               aluop   = 2'b01;
               branch  = 1'b1;
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               alusrc  = 1'b1;
               wait_d  = c_wait_ld;
               state_d = S_MEM;
            end
         end
         S_MEM: begin
            alusrc = 1'b1;
            mem_cs = 1'b1;
            mem_we = w_is_sw;
            // Counter holds the number of MEM cycles still to go after this one.
            if (wait_q == 4'd0) begin
               if (w_is_sw) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         S_WB: begin
            regwrite = 1'b1;
            done     = 1'b1;
            state_d  = S_IDLE;
            if (w_is_r) begin
               regdst = 1'b1;
               aluop  = 2'b10;
            end else begin
               memtoreg = 1'b1;
               alusrc   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign count_d = done ? count_q + CNT_W'(1) : count_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ir_q    <= 32'd0;
         wait_q  <= 4'd0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         wait_q  <= wait_d;
         count_q <= count_d;
      end
   end

   assign ir          = ir_q;
   assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multicycle_sequencer : trace-model bench for the sequencer      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_multicycle_sequencer;

   localparam int MW = 3;
   localparam int CW = 10;

   localparam logic [11:0] B_READY = 12'h800;
   localparam logic [11:0] B_RDST  = 12'h400;
   localparam logic [11:0] B_ASRC  = 12'h200;
   localparam logic [11:0] B_M2R   = 12'h100;
   localparam logic [11:0] B_OPSUB = 12'h040;
   localparam logic [11:0] B_OPFN  = 12'h080;
   localparam logic [11:0] B_BR    = 12'h020;
   localparam logic [11:0] B_RW    = 12'h010;
   localparam logic [11:0] B_CS    = 12'h008;
   localparam logic [11:0] B_WE    = 12'h004;
   localparam logic [11:0] B_DONE  = 12'h002;
   localparam logic [11:0] B_ILL   = 12'h001;

   localparam logic [31:0] W_R   = 32'h012A4020;
   localparam logic [31:0] W_LW  = 32'h8C880004;
   localparam logic [31:0] W_SW  = 32'hAC880004;
   localparam logic [31:0] W_ILL = 32'h08000000;
   localparam logic [31:0] W_BEQ = 32'h10850003;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          newinstr = 1'b0;
   logic [31:0]   instrword = 32'd0;
   logic          ready, regdst, alusrc, memtoreg, branch, regwrite;
   logic          mem_cs, mem_we, done, illegal;
   logic [1:0]    aluop;
   logic [31:0]   ir;
   logic [CW-1:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected per-cycle control traces still to be played out.
   logic [11:0]   sched[$];
   logic [31:0]   m_ir  = 32'd0;
   logic [CW-1:0] m_cnt = '0;

   multicycle_sequencer #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .newinstr(newinstr), .instrword(instrword),
      .ready(ready), .ir(ir), .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg),
      .aluop(aluop), .branch(branch), .regwrite(regwrite), .mem_cs(mem_cs),
      .mem_we(mem_we), .done(done), .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic plan(input logic [31:0] w);
      case (w[31:26])
         6'd0: begin
            sched.push_back(12'h000);
            sched.push_back(B_OPFN);
            sched.push_back(B_OPFN | B_RDST | B_RW | B_DONE);
         end
         6'd35: begin
            sched.push_back(12'h000);
            sched.push_back(B_ASRC);
            for (int i = 0; i < MW; i++) sched.push_back(B_ASRC | B_CS);
            sched.push_back(B_ASRC | B_M2R | B_RW | B_DONE);
         end
         6'd43: begin
            sched.push_back(12'h000);
            sched.push_back(B_ASRC);
            for (int i = 0; i < MW; i++)
               sched.push_back(B_ASRC | B_CS | B_WE | ((i == MW-1) ? B_DONE : 12'h000));
         end
         6'd4: begin
            sched.push_back(12'h000);
            sched.push_back(B_OPSUB | B_BR | B_DONE);
         end
         default: sched.push_back(B_ILL);
      endcase
   endtask

   task automatic model_edge();
      if (!reset) begin
         sched.delete();
         m_ir  = 32'd0;
         m_cnt = '0;
      end else if (sched.size() == 0) begin
         if (newinstr) begin
            m_ir = instrword;
            plan(instrword);
         end
      end else begin
         if (sched[0][1]) m_cnt = m_cnt + 1'b1;
         void'(sched.pop_front());
      end
   endtask

   task automatic compare();
      logic [11:0] obs, exp;
      obs = {ready, regdst, alusrc, memtoreg, aluop, branch, regwrite,
             mem_cs, mem_we, done, illegal};
      exp = (sched.size() != 0) ? sched[0] : B_READY;
      check_eq("ctl", {20'd0, obs}, {20'd0, exp});
      check_eq("ir", ir, m_ir);
      check_eq("cnt", {{(32-CW){1'b0}}, instr_count}, {{(32-CW){1'b0}}, m_cnt});
   endtask

   task automatic cyc(input logic rn, input logic ni, input logic [31:0] w);
      reset     = rn;
      newinstr  = ni;
      instrword = w;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare();
   endtask

   initial begin
      logic [31:0] r;
      logic [5:0]  op;
      int          guard;

      // Reset, then abort an lw mid-flight with a two-cycle reset.
      cyc(1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, W_LW);
      cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b0, 32'd0);
      check_eq("rst_ready", {31'd0, ready}, 32'd1);
      check_eq("rst_cnt", {{(32-CW){1'b0}}, instr_count}, 32'd0);
      check_eq("rst_ir", ir, 32'd0);

      // R-type, lw and sw, each followed by idle cycles.
      cyc(1'b1, 1'b1, W_R);
      repeat (4) cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, W_LW);
      repeat (7) cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, W_SW);
      repeat (6) cyc(1'b1, 1'b0, 32'd0);

      // Illegal opcode with newinstr pulses while busy, then beq.
      cyc(1'b1, 1'b1, W_ILL);
      cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, W_BEQ);
      cyc(1'b1, 1'b1, 32'hDEADBEEF);
      cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 32'h12345678);
      cyc(1'b1, 1'b0, 32'd0);

      // newinstr held high: four R-types back to back.
      repeat (16) cyc(1'b1, 1'b1, W_R);
      repeat (3) cyc(1'b1, 1'b0, 32'd0);

      // Counter wrap: retire beqs until all-ones, then one more.
      cyc(1'b0, 1'b0, 32'd0);
      guard = 0;
      while (m_cnt != '1 && guard < 8000) begin
         cyc(1'b1, 1'b1, W_BEQ);
         guard++;
      end
      check_eq("wrap_pre", {{(32-CW){1'b0}}, instr_count}, {{(32-CW){1'b0}}, {CW{1'b1}}});
      guard = 0;
      while (m_cnt != '0 && guard < 10) begin
         cyc(1'b1, 1'b1, W_BEQ);
         guard++;
      end
      check_eq("wrap", {{(32-CW){1'b0}}, instr_count}, 32'd0);
      repeat (3) cyc(1'b1, 1'b0, 32'd0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom();
         case ($urandom_range(0, 4))
            0:       op = 6'd0;
            1:       op = 6'd35;
            2:       op = 6'd43;
            3:       op = 6'd4;
            default: op = r[31:26];
         endcase
         cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1), {op, r[25:0]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
